vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster generator with a pixel-clock-enable divider, configurable porches and sync polarities, and a one-slot colour pipeline. It composites a background layer and an overlay layer. It drives the monitor pins (hsync, vsync, colour) and exports the current raster coordinate to the upstream renderers: game field, interface, reward and mine layers. It succeeds the fixed 640x480, hard-coded-offset, OR-only display timing block.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48, horizontal front porch / sync / back porch in pixel slots
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical porches in lines
- HS_POL, 0 / VS_POL, 0, asserted sync level (0 = active-low)
- CLK_DIV, 4, clk cycles per pixel slot (>=1)
- COLOR_W, 12, colour width
- MIX_MODE, 0, 0 = bitwise OR of layers; 1 = overlay wins when nonzero
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL (525); XW = clog2(H_TOTAL); YW = clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable
- bg_color  in  COLOR_W  background layer colour for the current x_pos/y_pos
- ov_color  in  COLOR_W  overlay layer colour for the current x_pos/y_pos
- pix_ce  out  1  one-clk pulse that opens each pixel slot
- x_pos  out  XW  current horizontal count, 0..H_TOTAL-1
- y_pos  out  YW  current vertical count, 0..V_TOTAL-1
- de  out  1  current slot is visible (x_pos<H_ACTIVE and y_pos<V_ACTIVE)
- line_start  out  1  one-clk pulse with pix_ce when x_pos becomes 0
- frame_start  out  1  one-clk pulse with pix_ce when x_pos and y_pos both become 0
- hsync  out  1  horizontal sync, pipeline-aligned to color_out
- vsync  out  1  vertical sync, pipeline-aligned to color_out
- color_out  out  COLOR_W  composited pixel; 0 outside the visible area

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. pix_ce is asserted on the clk where div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_ce is constantly high while en=1.
- Raster counters advance only on pix_ce.
  - x wraps from H_TOTAL-1 to 0 and increments y.
  - y wraps from V_TOTAL-1 to 0.
  - No other wrap points exist.
- Region order per line: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical uses the same order with the V_* parameters.
- Stage 1 (coordinate stage): x_pos, y_pos and de describe the slot in progress. The upstream renderers present bg_color/ov_color for that coordinate before the slot ends.
- Stage 2 (output stage): on the pix_ce that ends a slot, the block registers:
  - hsync/vsync for that slot's coordinate
  - color_out = mix(bg,ov) if that slot's de=1, else 0
- mix rule: MIX_MODE 0 gives bg|ov. MIX_MODE 1 gives ov if ov!=0, else bg.
- en=0:
  - div_cnt clears and pix_ce stays 0.
  - All counters and outputs hold.
  - On re-enable, the first pix_ce arrives CLK_DIV clks later.
- The widths of x_pos and y_pos are exact; no signed offsets are used. Visibility is tested only by de.

## Timing
- Reset (rst_n=0, async):
  - div_cnt=0, x_pos=0, y_pos=0, de=1 (coordinate 0,0 is visible)
  - pix_ce=0, line_start=0, frame_start=0
  - hsync=~HS_POL, vsync=~VS_POL, color_out=0
- Reset applied mid-frame takes effect immediately. After release, the raster restarts at (0,0) with no partial frame.
- Latency: coordinate to hsync/vsync/color_out is exactly one pixel slot (CLK_DIV clks). All three change on the same clk edge.
- de, x_pos and y_pos update on the clk edge after a pix_ce. line_start and frame_start are combinational from the same pix_ce and next-state wrap.
- hsync is asserted for exactly H_SYNC slots per line. vsync is asserted for exactly V_SYNC lines, with edges aligned to the x=0 slot output.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 at default parameters).

## Test plan
- Defaults, bg=12'h00F, ov=0 -> one hsync low pulse of 96 slots (384 clks) per 800 slots. The first low output corresponds to x=656. color_out=12'h00F only for x<640 and y<480, else 0.
- Defaults, measure vsync -> low for exactly 1600 slots, covering y=490..491. frame_start period = 1,680,000 clks.
- MIX_MODE=0, bg=12'h0F0, ov=12'hF00 -> color_out=12'hFF0. MIX_MODE=1 with the same inputs -> 12'hF00. MIX_MODE=1, ov=0 -> 12'h0F0.
- CLK_DIV=1, HS_POL=1, VS_POL=1 -> pix_ce constantly high. hsync idles low and is high for 96 clks. color_out lags the coordinate by 1 clk.
- rst_n pulsed low at x=300, y=200 -> all outputs at reset values within the same cycle. After release, x_pos=0 and y_pos=0, and the first frame_start comes after one full frame.
- en dropped for 50 clks at x=10 -> x_pos, hsync and color_out frozen. On resume, x_pos=11 after CLK_DIV clks and line timing continues unbroken.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-enable divider, raster counters,
// sync decode and a one-slot colour/sync output register stage.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 4,
  parameter int COLOR_W  = 12,
  parameter int MIX_MODE = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic [COLOR_W-1:0] ov_color,
  output logic               pix_ce,
  output logic [XW-1:0]      x_pos,
  output logic [YW-1:0]      y_pos,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] color_out
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [XW:0] X_ACT  = (XW+1)'(H_ACTIVE);
  localparam logic [YW:0] Y_ACT  = (YW+1)'(V_ACTIVE);
  localparam logic [XW:0] HS_BEG = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_END = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0] VS_BEG = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_END = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic [DW-1:0]      div_cnt;
  logic               x_wrap;
  logic               y_wrap;
  logic [XW-1:0]      x_nxt;
  logic [YW-1:0]      y_nxt;
  logic               hs_act;
  logic               vs_act;
  logic [COLOR_W-1:0] mix;

  // rst_n gating keeps pix_ce low in reset even when CLK_DIV=1
  assign pix_ce = en & rst_n & (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || pix_ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign x_wrap = (x_pos == X_LAST);
  assign y_wrap = (y_pos == Y_LAST);

  always_comb begin
    x_nxt = x_pos + 1'b1;
    y_nxt = y_pos;
    if (x_wrap) begin
      x_nxt = '0;
      y_nxt = y_wrap ? '0 : y_pos + 1'b1;
    end
  end

  assign line_start  = pix_ce & x_wrap;
  assign frame_start = line_start & y_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos <= '0;
      y_pos <= '0;
      de    <= 1'b1;
    end else if (pix_ce) begin
      x_pos <= x_nxt;
      y_pos <= y_nxt;
      de    <= ({1'b0, x_nxt} < X_ACT) && ({1'b0, y_nxt} < Y_ACT);
    end
  end

  assign hs_act = ({1'b0, x_pos} >= HS_BEG) && ({1'b0, x_pos} < HS_END);
  assign vs_act = ({1'b0, y_pos} >= VS_BEG) && ({1'b0, y_pos} < VS_END);

  always_comb begin
    mix = bg_color | ov_color;
    if (MIX_MODE != 0) begin
      mix = (ov_color != '0) ? ov_color : bg_color;
    end
  end

  // output stage captures the slot that is ending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync     <= ~HS_ON;
      vsync     <= ~VS_ON;
      color_out <= '0;
    end else if (pix_ce) begin
      hsync     <= hs_act ? HS_ON : ~HS_ON;
      vsync     <= vs_act ? VS_ON : ~VS_ON;
      color_out <= de ? mix : '0;
    end
  end

endmodule
